// File: rtl/tdc_hit_sequencer.sv
// -----------------------------------------------------------------------------
// tdc_hit_sequencer
//
// Sequences one channel of a multi-phase TDC delay line. While armed, a
// synchronised hit latches the 4*LENGTH-bit tap snapshot together with a
// free-running coarse count. The fine position (index of the lowest 0 tap) is
// then encoded, and {coarse, fine} is queued in a small first-word-fall-through
// FIFO toward the readout. A dead time follows every accepted hit.
//
// Optional feature (compile-time macro TDC_BUBBLE_FILTER_EN):
//   adds a FILTER state between capture and encode that replaces every inner
//   snapshot bit by the majority of itself and its two neighbours, removing
//   single-tap bubbles at the cost of one extra cycle of latency.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   arm       in   level, enables hit capture
//   hit       in   hit strobe, synchronous to clk
//   taps      in   TW-bit tap snapshot
//   ts_data   out  {coarse, fine} of the FIFO head, 0 when empty
//   ts_valid  out  FIFO non-empty
//   ts_ready  in   consumer accepts the head when ts_valid && ts_ready
//   busy      out  channel is in capture/encode/push/dead processing
//   drop_cnt  out  saturating count of hits lost to a full FIFO
// -----------------------------------------------------------------------------
module tdc_hit_sequencer #(
    parameter int  LENGTH      = 8,
    parameter int  COARSE_W    = 16,
    parameter int  FIFO_DEPTH  = 4,
    parameter int  DEAD_CYCLES = 3,
    localparam int TW          = 4 * LENGTH,
    localparam int FINE_W      = $clog2(TW + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm,
    input  logic                       hit,
    input  logic [TW-1:0]              taps,
    output logic [COARSE_W+FINE_W-1:0] ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    localparam int ENTRY_W   = COARSE_W + FINE_W;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int DC_W      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    // The counter is loaded with DEAD_CYCLES-1 so that DEAD lasts exactly
    // DEAD_CYCLES cycles including the exit cycle.
    localparam int DEAD_LOAD = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
`ifdef TDC_BUBBLE_FILTER_EN
        S_FILTER,
`endif
        S_ENCODE,
        S_PUSH,
        S_DEAD
    } state_t;

    state_t              state_q, state_d;
    logic [COARSE_W-1:0] coarse_q;
    logic [COARSE_W-1:0] c_lat_q, c_lat_d;
    logic [TW-1:0]       snap_q, snap_d;
    logic [FINE_W-1:0]   fine_q, fine_d;
    logic [DC_W-1:0]     dead_cnt_q, dead_cnt_d;
    logic [FINE_W-1:0]   fine_enc;
    logic                push_req;

    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [7:0]          drop_q;
    logic                fifo_pop, fifo_wr, fifo_drop;

`ifdef TDC_BUBBLE_FILTER_EN
    // Majority-of-three smoothing; the two end taps have only one neighbour
    // and pass through unchanged.
    logic [TW-1:0] snap_filt;
    assign snap_filt[0]    = snap_q[0];
    assign snap_filt[TW-1] = snap_q[TW-1];
    for (genvar gi = 1; gi < TW - 1; gi++) begin : g_bubble
        assign snap_filt[gi] = (snap_q[gi-1] & snap_q[gi])
                             | (snap_q[gi-1] & snap_q[gi+1])
                             | (snap_q[gi]   & snap_q[gi+1]);
    end
`endif

    // Lowest-zero priority encoder: scanning from the top down lets the lowest
    // zero win; an all-ones snapshot leaves the default of TW.
    always_comb begin
        fine_enc = FINE_W'(TW);
        for (int i = TW - 1; i >= 0; i--) begin
            if (!snap_q[i]) begin
                fine_enc = FINE_W'(i);
            end
        end
    end

    // Coarse counter: free running, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_q <= '0;
        end else begin
            coarse_q <= coarse_q + COARSE_W'(1);
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        c_lat_d    = c_lat_q;
        snap_d     = snap_q;
        fine_d     = fine_q;
        dead_cnt_d = dead_cnt_q;
        push_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    snap_d  = taps;
                    // Pre-increment value: the count seen at the hit edge.
                    c_lat_d = coarse_q;
`ifdef TDC_BUBBLE_FILTER_EN
                    state_d = S_FILTER;
`else
                    state_d = S_ENCODE;
`endif
                end
            end
`ifdef TDC_BUBBLE_FILTER_EN
            S_FILTER: begin
                snap_d  = snap_filt;
                state_d = S_ENCODE;
            end
`endif
            S_ENCODE: begin
                fine_d  = fine_enc;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                push_req = 1'b1;
                if (DEAD_CYCLES == 0) begin
                    state_d = arm ? S_ARMED : S_IDLE;
                end else begin
                    dead_cnt_d = DC_W'(DEAD_LOAD);
                    state_d    = S_DEAD;
                end
            end
            S_DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = arm ? S_ARMED : S_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            c_lat_q    <= '0;
            snap_q     <= '0;
            fine_q     <= '0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            c_lat_q    <= c_lat_d;
            snap_q     <= snap_d;
            fine_q     <= fine_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_ARMED);

    // FIFO control. A read in the same edge frees a slot, so a push into a
    // full FIFO is still accepted when the head is being consumed.
    assign fifo_pop  = (count_q != '0) && ts_ready;
    assign fifo_wr   = push_req && ((count_q != CNT_W'(FIFO_DEPTH)) || fifo_pop);
    assign fifo_drop = push_req && !fifo_wr;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= {c_lat_q, fine_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (fifo_drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign ts_valid = (count_q != '0);
    assign ts_data  = ts_valid ? fifo_mem[rd_ptr_q] : '0;
    assign drop_cnt = drop_q;

endmodule

// File: doc/tdc_hit_sequencer.md
Name: tdc_hit_sequencer

Overview:
- Sequences one channel of the multi-phase TDC delay line (4 phase taps per stage, LENGTH stages, 4*LENGTH-bit snapshot).
- Arms the channel and latches the tap snapshot plus a free-running coarse count on a synchronised hit.
- Encodes the fine position, enforces dead time, and buffers timestamps in a small FIFO toward the readout with a valid/ready handshake.

Parameters:
- LENGTH, 8, delay-line stages; tap vector width TW = 4*LENGTH.
- COARSE_W, 16, coarse counter width.
- FIFO_DEPTH, 4, timestamp FIFO entries; power of two, minimum 2.
- DEAD_CYCLES, 3, dead-time cycles after each accepted hit; minimum 0.
- FINE_W, derived: clog2(TW+1).

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  level; high enables hit capture.
- hit  in  1  hit strobe, already synchronised to clk.
- taps  in  TW  tap snapshot from the delay line, stable in clk domain.
- ts_data  out  COARSE_W+FINE_W  {coarse, fine} of the FIFO head.
- ts_valid  out  1  FIFO non-empty.
- ts_ready  in  1  consumer accepts the head when ts_valid and ts_ready are both high.
- busy  out  1  state is not IDLE or ARMED.
- drop_cnt  out  8  saturating count of hits lost to a full FIFO.

Behaviour:
- Reset values:
  - state=IDLE; coarse=0; FIFO empty.
  - ts_valid=0, ts_data=0, busy=0, drop_cnt=0.
  - Reset asserted mid-operation discards pending and buffered data immediately.
- Coarse counter: increments every clk; wraps from 2^COARSE_W-1 to 0; never stops.
- State machine: IDLE, ARMED, ENCODE, PUSH, DEAD.
  - IDLE: moves to ARMED when arm=1.
  - ARMED:
    - arm=0: return to IDLE.
    - hit=1 at edge N: latch taps into snap and the pre-increment coarse value into c_lat; go to ENCODE.
    - arm and hit both high: the hit is captured.
  - ENCODE (edge N+1): fine = index of the lowest 0 bit in snap; all-ones gives fine=TW; snap bit0=0 gives fine=0.
  - PUSH (edge N+2):
    - FIFO not full: write {c_lat, fine}.
    - FIFO full: no write; drop_cnt increments, saturating at 255.
    - Both cases go to DEAD, or to ARMED/IDLE directly when DEAD_CYCLES=0.
  - DEAD: counts DEAD_CYCLES cycles; hits are ignored and never counted. Then goes to ARMED if arm=1, else IDLE.
- arm deasserted during ENCODE, PUSH or DEAD: the in-flight hit still completes; return to IDLE afterwards.
- Latency: with the FIFO empty and ts_ready=0, ts_valid rises after edge N+2, i.e. visible in the cycle following the PUSH edge.
- Hit-to-hit minimum spacing: 3+DEAD_CYCLES cycles.
- FIFO:
  - Standard first-word-fall-through; ts_data reflects the head whenever ts_valid=1; ts_data is 0 when empty.
  - Simultaneous write and read when full: the write is accepted, because the read frees the slot in the same edge.
  - Pointers wrap modulo FIFO_DEPTH.
- busy=1 in ENCODE, PUSH and DEAD.

Optional Feature:
- Macro: TDC_BUBBLE_FILTER_EN.
- Defined:
  - Inserts a FILTER state between ARMED and ENCODE.
  - Each snap bit i (1..TW-2) is replaced by the majority of bits i-1, i, i+1; end bits pass unchanged.
  - Adds one cycle: write at edge N+3; minimum hit spacing becomes 4+DEAD_CYCLES.
- Undefined: no FILTER state; timing as stated above.

Test Plan:
- Basic timing:
  - Stimulus: reset, arm=1, ts_ready=1, taps=32'h0000_00FF, hit pulse when coarse=100.
  - Response: ts_valid for one cycle with ts_data={16'd100, 6'd8}; busy high for 2+3 cycles.
- Encoder boundaries: taps=32'hFFFF_FFFF then 32'h0000_0000 on two spaced hits -> fine=32 then fine=0.
- Overflow:
  - Stimulus: ts_ready=0; six spaced hits.
  - Response: 4 entries retained in order; drop_cnt=2; draining with ts_ready=1 returns the first four coarse values.
- Dead time:
  - Stimulus: second hit 2 cycles after the first accepted hit.
  - Response: ignored; drop_cnt unchanged; one entry only.
- Wrap and reset:
  - Stimulus: hit when coarse=16'hFFFF, next hit 6 cycles later; then rst_n=0 pulse while in DEAD with 2 entries buffered.
  - Response: coarse values 16'hFFFF then 16'h0005; after reset ts_valid=0, drop_cnt=0, state IDLE.
- Bubble filter (TDC_BUBBLE_FILTER_EN defined):
  - Stimulus: taps=32'h0000_00F7 (bubble at bit3).
  - Response: fine=8, written at edge N+3.
  - Without the macro: fine=3.
